hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared CPU definitions for the hazard controller
// Contents: register-index width, stall-counter width, FSM state encoding,
//           register dependency helper.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    LD_BR = 2'b01
  } state_e;

  // $0 is hardwired to zero, so writing it never creates a dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] wr,
                                   input logic [REG_W-1:0] src);
    return (wr != '0) && (wr == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
// master: pipeline side (drives ID/EX status, receives control enables)
// slave : hazard_ctrl side
//   IFID_rs_i/IFID_rt_i/IFID_useRt_i - ID instruction sources
//   Branch_i/BrTaken_i               - ID beq and its outcome
//   IDEX_MemRead_i/IDEX_RegWrite_i/IDEX_wr_i - EX instruction info
//   mem_stall_i                      - memory busy, freezes pipeline
//   Hazard_o/PCWrite_o/IFIDWrite_o/Flush_o/stall_cnt_o - control outputs
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] IFID_rs_i;
  logic [REG_W-1:0] IFID_rt_i;
  logic             IFID_useRt_i;
  logic             Branch_i;
  logic             BrTaken_i;
  logic             IDEX_MemRead_i;
  logic             IDEX_RegWrite_i;
  logic [REG_W-1:0] IDEX_wr_i;
  logic             mem_stall_i;
  logic             Hazard_o;
  logic             PCWrite_o;
  logic             IFIDWrite_o;
  logic             Flush_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output IFID_rs_i, IFID_rt_i, IFID_useRt_i, Branch_i, BrTaken_i,
           IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_wr_i, mem_stall_i,
    input  Hazard_o, PCWrite_o, IFIDWrite_o, Flush_o, stall_cnt_o
  );

  modport slave (
    input  IFID_rs_i, IFID_rt_i, IFID_useRt_i, Branch_i, BrTaken_i,
           IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_wr_i, mem_stall_i,
    output Hazard_o, PCWrite_o, IFIDWrite_o, Flush_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating up-counter
//   clk_i - clock, rst_i - async active-low reset
//   inc_i - increment request, cnt_o - count (sticks at all-ones)
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch hazard detection and stall control
//   clk_i - pipeline clock, rst_i - async active-low reset
//   hz    - hazard_ctrl_if.slave bundle (ID/EX status in, enables out)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  hz
);

  state_e state_q;
  state_e state_d;

  logic dep;
  logic load_use;
  logic br_alu;
  logic br_ld;
  logic hazard;

  assign dep = reg_dep(hz.IDEX_wr_i, hz.IFID_rs_i) ||
               (hz.IFID_useRt_i && reg_dep(hz.IDEX_wr_i, hz.IFID_rt_i));

  assign load_use = hz.IDEX_MemRead_i && dep;
  assign br_alu   = hz.Branch_i && hz.IDEX_RegWrite_i && !hz.IDEX_MemRead_i && dep;
  // A beq waiting on a load needs the loaded value compared in ID: two bubbles.
  assign br_ld    = hz.Branch_i && hz.IDEX_MemRead_i && dep;

  always_comb begin
    state_d = state_q;
    hazard  = 1'b0;
    case (state_q)
      RUN: begin
        hazard = load_use || br_alu || br_ld;
        if (br_ld) state_d = LD_BR;
      end
      LD_BR: begin
        hazard  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // A memory stall freezes everything, including the FSM.
    if (hz.mem_stall_i) begin
      hazard  = 1'b0;
      state_d = state_q;
    end
    // Outputs are forced to the idle values while reset is held.
    if (!rst_i) begin
      hazard = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.Hazard_o    = hazard;
  assign hz.PCWrite_o   = !rst_i || (!hz.mem_stall_i && !hazard);
  assign hz.IFIDWrite_o = !rst_i || (!hz.mem_stall_i && !hazard);
  assign hz.Flush_o     = rst_i && hz.Branch_i && hz.BrTaken_i &&
                          !hazard && !hz.mem_stall_i;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (hazard),
    .cnt_o (hz.stall_cnt_o)
  );

endmodule
